// File: rtl/scan_pkg.sv
// rtl/scan_pkg.sv - shared state encoding, widths and popcount for scan_encoder16x4
package scan_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EMIT = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam int N_LINES = 16;
    localparam int CODE_W  = 4;

    function automatic logic [CODE_W:0] popcount16(input logic [N_LINES-1:0] v);
        logic [CODE_W:0] c;
        c = '0;
        for (int i = 0; i < N_LINES; i++) begin
            c = c + (CODE_W+1)'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/scan_encoder16x4_if.sv
// rtl/scan_encoder16x4_if.sv - request load and code handshake bundle
interface scan_encoder16x4_if;
    import scan_pkg::*;

    logic [N_LINES-1:0] req;
    logic               load;
    logic               ready;
    logic [CODE_W-1:0]  code;
    logic               valid;
    logic               busy;
    logic               done;
    logic [CODE_W:0]    remaining;

    modport master (
        output req, load, ready,
        input  code, valid, busy, done, remaining
    );

    modport slave (
        input  req, load, ready,
        output code, valid, busy, done, remaining
    );

endinterface

// File: rtl/encoder4x2.sv
// rtl/encoder4x2.sv - combinational 4-to-2 priority encoder, bit 3 highest
module encoder4x2 (
    input  logic [3:0] d,
    output logic [1:0] y,
    output logic       any
);

    always_comb begin
        y = 2'd0;
        if (d[3])      y = 2'd3;
        else if (d[2]) y = 2'd2;
        else if (d[1]) y = 2'd1;
    end

    assign any = |d;

endmodule

// File: rtl/scan_encoder16x4.sv
// rtl/scan_encoder16x4.sv - sequential 16-to-4 priority encoder, emits every set index highest first
module scan_encoder16x4
    import scan_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    scan_encoder16x4_if.slave bus
);

    state_t             state_q, state_d;
    logic [N_LINES-1:0] pending_q, pending_d;
    logic [N_LINES-1:0] cleared;
    logic [1:0]         nib_y [4];
    logic [3:0]         nib_any;
    logic [CODE_W-1:0]  enc_code;
    logic               enc_any;

    // Nibble encoders feed a second-level encoder that picks the highest non-empty nibble.
    for (genvar g = 0; g < 4; g++) begin : g_nib
        encoder4x2 u_nib (
            .d   (pending_q[4*g +: 4]),
            .y   (nib_y[g]),
            .any (nib_any[g])
        );
    end

    encoder4x2 u_top (
        .d   (nib_any),
        .y   (enc_code[3:2]),
        .any (enc_any)
    );

    assign enc_code[1:0] = nib_y[enc_code[3:2]];
    assign cleared       = pending_q & ~(N_LINES'(1) << enc_code);

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        case (state_q)
            IDLE: begin
                if (bus.load && (bus.req != '0)) begin
                    pending_d = bus.req;
                    state_d   = EMIT;
                end
            end
            EMIT: begin
                if (bus.ready) begin
                    pending_d = cleared;
                    if (cleared == '0) state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
        end
    end

    // Outputs depend only on registered state; pending is nonzero throughout EMIT.
    assign bus.valid     = (state_q == EMIT) && enc_any;
    assign bus.code      = bus.valid ? enc_code : '0;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.remaining = popcount16(pending_q);

endmodule

// File: tb/tb_scan_encoder16x4.sv
// tb/tb_scan_encoder16x4.sv - scoreboard bench for scan_encoder16x4
module tb_scan_encoder16x4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    scan_encoder16x4_if bus ();

    scan_encoder16x4 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    logic [3:0] exp_q [$];
    int vec_cnt = 0;
    int err_cnt = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input logic [15:0] r);
        for (int i = 15; i >= 0; i--) begin
            if (r[i]) exp_q.push_back(4'(i));
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; bus.load = 1'b0; bus.ready = 1'b0; bus.req = '0;
        tick; tick;
        vec_cnt++;
        if ({bus.code, bus.valid, bus.busy, bus.done, bus.remaining} !== 12'd0) begin
            err_cnt++;
            $display("FAIL reset_outputs: got code=%0d valid=%0b busy=%0b done=%0b rem=%0d, want all 0",
                     bus.code, bus.valid, bus.busy, bus.done, bus.remaining);
        end
        rst = 1'b0;
        tick;
    endtask

    task automatic test_basic;
        int cyc = 0;
        bit seen_done = 0;
        bus.req = 16'h8004; bus.load = 1'b1; bus.ready = 1'b1;
        push_exp(16'h8004);
        tick;
        bus.load = 1'b0;
        for (int c = 0; c < 10; c++) begin
            if (bus.done) begin seen_done = 1; break; end
            if (bus.valid) begin
                cyc++; vec_cnt++;
                if (exp_q.size() == 0) begin
                    err_cnt++; $display("FAIL basic_extra: code=%0d emitted, none expected", bus.code);
                end else if (bus.code !== exp_q[0] || bus.remaining !== 5'(exp_q.size())) begin
                    err_cnt++;
                    $display("FAIL basic_code: got code=%0d rem=%0d, want code=%0d rem=%0d",
                             bus.code, bus.remaining, exp_q[0], exp_q.size());
                end
                if (bus.ready) void'(exp_q.pop_front());
            end
            tick;
        end
        vec_cnt++;
        if (!seen_done || cyc != 2 || bus.remaining !== 5'd0) begin
            err_cnt++;
            $display("FAIL basic_done: done=%0b emit_cycles=%0d rem=%0d, want done=1 cycles=2 rem=0",
                     seen_done, cyc, bus.remaining);
        end
        tick;
        vec_cnt++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            err_cnt++;
            $display("FAIL basic_idle: done=%0b busy=%0b, want 0 0", bus.done, bus.busy);
        end
    endtask

    task automatic test_backpressure;
        bit seen_done = 0;
        bus.req = 16'h0028; bus.load = 1'b1; bus.ready = 1'b0;
        push_exp(16'h0028);
        tick;
        bus.load = 1'b0;
        for (int c = 0; c < 3; c++) begin
            vec_cnt++;
            if (bus.valid !== 1'b1 || bus.code !== 4'd5 || bus.remaining !== 5'd2) begin
                err_cnt++;
                $display("FAIL bp_hold: cycle %0d valid=%0b code=%0d rem=%0d, want 1 5 2",
                         c, bus.valid, bus.code, bus.remaining);
            end
            tick;
        end
        bus.ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (bus.done) begin seen_done = 1; break; end
            if (bus.valid) begin
                vec_cnt++;
                if (exp_q.size() == 0) begin
                    err_cnt++; $display("FAIL bp_extra: code=%0d emitted, none expected", bus.code);
                end else if (bus.code !== exp_q[0] || bus.remaining !== 5'(exp_q.size())) begin
                    err_cnt++;
                    $display("FAIL bp_code: got code=%0d rem=%0d, want code=%0d rem=%0d",
                             bus.code, bus.remaining, exp_q[0], exp_q.size());
                end
                if (bus.ready) void'(exp_q.pop_front());
            end
            tick;
        end
        vec_cnt++;
        if (!seen_done || exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL bp_done: done=%0b left=%0d, want done=1 left=0", seen_done, exp_q.size());
        end
        tick;
    endtask

    task automatic test_ignored_loads;
        bit seen_done = 0;
        bus.req = 16'h0000; bus.load = 1'b1; bus.ready = 1'b1;
        tick;
        vec_cnt++;
        if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.remaining !== 5'd0) begin
            err_cnt++;
            $display("FAIL zero_load: busy=%0b valid=%0b rem=%0d, want 0 0 0", bus.busy, bus.valid, bus.remaining);
        end
        bus.req = 16'h0001; bus.ready = 1'b0;
        push_exp(16'h0001);
        tick;
        bus.req = 16'hFFFF;
        tick;
        vec_cnt++;
        if (bus.code !== 4'd0 || bus.remaining !== 5'd1 || bus.valid !== 1'b1) begin
            err_cnt++;
            $display("FAIL emit_load: code=%0d rem=%0d valid=%0b, want 0 1 1", bus.code, bus.remaining, bus.valid);
        end
        bus.ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            if (bus.done) begin seen_done = 1; break; end
            if (bus.valid) begin
                vec_cnt++;
                if (exp_q.size() == 0) begin
                    err_cnt++; $display("FAIL ign_extra: code=%0d emitted, none expected", bus.code);
                end else if (bus.code !== exp_q[0] || bus.remaining !== 5'(exp_q.size())) begin
                    err_cnt++;
                    $display("FAIL ign_code: got code=%0d rem=%0d, want code=%0d rem=%0d",
                             bus.code, bus.remaining, exp_q[0], exp_q.size());
                end
                if (bus.ready) void'(exp_q.pop_front());
            end
            tick;
        end
        bus.load = 1'b0;
        vec_cnt++;
        if (!seen_done || exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL ign_done: done=%0b left=%0d, want done=1 left=0", seen_done, exp_q.size());
        end
        tick;
    endtask

    task automatic test_full_word;
        int cyc = 0;
        bit seen_done = 0;
        bus.req = 16'hFFFF; bus.load = 1'b1; bus.ready = 1'b1;
        push_exp(16'hFFFF);
        tick;
        bus.load = 1'b0;
        vec_cnt++;
        if (bus.remaining !== 5'd16) begin
            err_cnt++; $display("FAIL full_rem16: rem=%0d, want 16", bus.remaining);
        end
        for (int c = 0; c < 40; c++) begin
            if (bus.done) begin seen_done = 1; break; end
            if (bus.valid) begin
                cyc++; vec_cnt++;
                if (exp_q.size() == 0) begin
                    err_cnt++; $display("FAIL full_extra: code=%0d emitted, none expected", bus.code);
                end else if (bus.code !== exp_q[0] || bus.remaining !== 5'(exp_q.size())) begin
                    err_cnt++;
                    $display("FAIL full_code: got code=%0d rem=%0d, want code=%0d rem=%0d",
                             bus.code, bus.remaining, exp_q[0], exp_q.size());
                end
                if (bus.ready) void'(exp_q.pop_front());
            end
            tick;
        end
        vec_cnt++;
        if (!seen_done || cyc != 16 || exp_q.size() != 0) begin
            err_cnt++;
            $display("FAIL full_done: done=%0b cycles=%0d left=%0d, want 1 16 0", seen_done, cyc, exp_q.size());
        end
        tick;
    endtask

    task automatic test_reset_mid;
        bus.req = 16'h00F0; bus.load = 1'b1; bus.ready = 1'b1;
        tick;
        bus.load = 1'b0;
        tick;
        vec_cnt++;
        if (bus.code !== 4'd6 || bus.valid !== 1'b1) begin
            err_cnt++; $display("FAIL mid_second: code=%0d valid=%0b, want 6 1", bus.code, bus.valid);
        end
        rst = 1'b1;
        tick;
        rst = 1'b0;
        vec_cnt++;
        if (bus.busy !== 1'b0 || bus.valid !== 1'b0 || bus.remaining !== 5'd0 || bus.done !== 1'b0) begin
            err_cnt++;
            $display("FAIL mid_reset: busy=%0b valid=%0b rem=%0d done=%0b, want all 0",
                     bus.busy, bus.valid, bus.remaining, bus.done);
        end
        tick;
        vec_cnt++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            err_cnt++; $display("FAIL mid_nodone: done=%0b busy=%0b, want 0 0", bus.done, bus.busy);
        end
        exp_q.delete();
    endtask

    initial begin
        test_reset;
        test_basic;
        test_backpressure;
        test_ignored_loads;
        test_full_word;
        test_reset_mid;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
